// File: rtl/pci_lbus_arb_if.sv
// ---------------------------------------------------------------------------
// pci_lbus_arb_if
//   Bundle between the local-bus requesters (config FSM, memory target,
//   JPEG DMA) and the round-robin local-bus arbiter.
//
//   Handshake: each requester raises req[i] as a level and keeps it high until
//   it has been granted and has finished. The arbiter answers with a one-hot,
//   registered gnt. The owner ends its tenure with a one-cycle done[i] pulse,
//   or by dropping req[i] (abort). Bits of done/req belonging to non-owners are
//   ignored while a grant is held.
//
//   Signals
//     req          requester -> arbiter  NREQ  level request per requester
//     done         requester -> arbiter  NREQ  1-cycle "transfer finished"
//     gnt          arbiter -> requester  NREQ  one-hot grant
//     gnt_id       arbiter -> requester  IDW   index of current/last owner
//     busy         arbiter -> requester  1     arbiter not idle
//     timeout_err  arbiter -> requester  1     1-cycle forced-release pulse
//
//   Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface pci_lbus_arb_if #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            timeout_err;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout_err
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout_err
  );
endinterface

// File: rtl/pci_lbus_arb.sv
// ---------------------------------------------------------------------------
// pci_lbus_arb
//   Round-robin arbiter for the PCI target's single internal local bus.
//   Grants one requester at a time, holds the grant until the owner signals
//   done (or drops its request), then spends one release cycle before the
//   next arbitration round.
//
//   Ports
//     clk       in   clock, all logic on posedge
//     rst       in   asynchronous reset, active-low
//     bus       slave modport of pci_lbus_arb_if (req/done in,
//               gnt/gnt_id/busy/timeout_err out)
//     state_o   out  current FSM state (IDLE=0, ARB=1, OWN=2, REL=3)
//
//   Configuration
//     PCI_ARB_TIMEOUT_EN  when defined, an ownership counter forces release
//                         after TIMEOUT OWN cycles and pulses timeout_err.
//                         When undefined no counter exists and timeout_err
//                         is tied low.
// ---------------------------------------------------------------------------
module pci_lbus_arb #(
  parameter int NREQ    = 3,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic           clk,
  input  logic           rst,
  pci_lbus_arb_if.slave  bus,
  output logic [1:0]     state_o
);

  // Elaboration-time parameter legality.
  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ) begin : g_bad_nreq
    $error("pci_lbus_arb: NREQ must be 2..8 and fit in IDW bits");
  end
  if (TIMEOUT < 1 || TIMEOUT >= (1 << TW)) begin : g_bad_timeout
    $error("pci_lbus_arb: TIMEOUT must be 1..2**TW-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARB  = 2'b01,
    OWN  = 2'b10,
    REL  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  last_q, last_d;

  // Round-robin search: start one past the last owner, wrap upward.
  logic           win_found;
  logic [IDW-1:0] win_id;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // Owner-only view of done/req; other bits are deliberately ignored.
  logic own_done;
  logic own_req;
  assign own_done = bus.done[gnt_id_q];
  assign own_req  = bus.req[gnt_id_q];

`ifdef PCI_ARB_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
  logic          expire;
  // cnt_q counts completed OWN cycles; the TIMEOUT-th OWN cycle is the last.
  assign expire = (cnt_q == TW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
`ifdef PCI_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) state_d = ARB;
      end
      ARB: begin
        // Requests may vanish between IDLE and ARB; no grant in that case.
        if (win_found) begin
          gnt_d    = NREQ'(1) << win_id;
          gnt_id_d = win_id;
          state_d  = OWN;
`ifdef PCI_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
`ifdef PCI_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // done wins over expiry, so a done on the expiry cycle is clean.
        if (own_done || !own_req) begin
          state_d = REL;
          gnt_d   = '0;
          last_d  = gnt_id_q;
        end
`ifdef PCI_ARB_TIMEOUT_EN
        else if (expire) begin
          state_d = REL;
          gnt_d   = '0;
          last_d  = gnt_id_q;
          terr_d  = 1'b1;
        end
`endif
      end
      REL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      last_q   <= IDW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
    end
  end

`ifdef PCI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = (state_q != IDLE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_pci_lbus_arb.sv
// ---------------------------------------------------------------------------
// tb_pci_lbus_arb
//   Directed bench for pci_lbus_arb. Expected grant owners are queued when a
//   request pattern is driven and popped when the next grant appears.
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled at the same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_pci_lbus_arb;
  localparam int NREQ    = 3;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 16;
  localparam int TW      = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_o;

  pci_lbus_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  pci_lbus_arb #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [IDW-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // ---------------- scoreboard / checks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant, checking gnt is never multi-hot meanwhile,
  // then compare against the oldest queued expected owner.
  task automatic wait_grant(input string tag, output logic [IDW-1:0] e_o);
    int n;
    n   = 0;
    e_o = '0;
    while (bus.gnt === '0 && n < 20) begin
      tick();
      n++;
      chk({tag, "_onehot0"}, 32'($onehot0(bus.gnt)), 32'd1);
    end
    checks++;
    assert (n < 20) else begin
      errors++;
      $error("FAIL %s_wait: observed no grant after %0d cycles, expected a grant", tag, n);
    end
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_queue: observed grant %0h, expected none queued", tag, bus.gnt);
    end
    if (exp_q.size() != 0) begin
      e_o = exp_q.pop_front();
      chk({tag, "_id"},  32'(bus.gnt_id), 32'(e_o));
      chk({tag, "_gnt"}, 32'(bus.gnt),    32'd1 << e_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [IDW-1:0] e;
    int hold;

    do_reset();
    chk("rst_gnt",   32'(bus.gnt), 0);
    chk("rst_id",    32'(bus.gnt_id), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_terr",  32'(bus.timeout_err), 0);
    chk("rst_state", 32'(state_o), 0);

    // 1: single request, exact latency
    bus.req = 3'b001;                           // cyc0
    tick();                                     // cyc1 (ARB)
    chk("t1_c1_gnt",  32'(bus.gnt), 0);
    chk("t1_c1_busy", 32'(bus.busy), 1);
    chk("t1_c1_state", 32'(state_o), 1);
    tick();                                     // cyc2 (OWN)
    chk("t1_c2_gnt", 32'(bus.gnt), 32'b001);
    chk("t1_c2_id",  32'(bus.gnt_id), 0);
    repeat (3) tick();                          // cyc5
    chk("t1_c5_gnt", 32'(bus.gnt), 32'b001);
    bus.done = 3'b001;
    bus.req  = 3'b000;
    tick();                                     // cyc6 (REL)
    bus.done = 3'b000;
    chk("t1_c6_gnt",   32'(bus.gnt), 0);
    chk("t1_c6_busy",  32'(bus.busy), 1);
    chk("t1_c6_state", 32'(state_o), 3);
    tick();                                     // cyc7 (IDLE)
    chk("t1_c7_busy", 32'(bus.busy), 0);
    chk("t1_c7_id",   32'(bus.gnt_id), 0);

    // 2: fairness from reset with all requests held
    do_reset();
    bus.req = 3'b111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(0); exp_q.push_back(1);
    for (int k = 0; k < 5; k++) begin
      wait_grant("t2", e);
      repeat (3) begin
        tick();
        chk("t2_hold", 32'(bus.gnt), 32'd1 << e);
      end
      bus.done = 3'b001 << e;
      if (k == 4) bus.req = 3'b000;
      tick();
      bus.done = 3'b000;
      chk("t2_rel", 32'(bus.gnt), 0);
    end
    tick();

    // 3: owner abort, then next winner is 2
    bus.req = 3'b010;
    exp_q.push_back(1);
    wait_grant("t3a", e);
    bus.req = 3'b110;
    tick();
    chk("t3_hold", 32'(bus.gnt), 32'b010);
    bus.req = 3'b100;                          // requester 1 aborts
    tick();
    chk("t3_abort_gnt", 32'(bus.gnt), 0);
    chk("t3_abort_id",  32'(bus.gnt_id), 1);
    exp_q.push_back(2);
    wait_grant("t3b", e);
    bus.done = 3'b100;
    bus.req  = 3'b000;
    tick();
    bus.done = 3'b000;
    chk("t3_rel", 32'(bus.gnt), 0);
    tick();

    // 5: stray done on non-owner bits is ignored
    bus.req = 3'b001;
    exp_q.push_back(0);
    wait_grant("t5", e);
    bus.done = 3'b110;
    tick();
    bus.done = 3'b000;
    chk("t5_stray1", 32'(bus.gnt), 32'b001);
    tick();
    chk("t5_stray2", 32'(bus.gnt), 32'b001);
    bus.done = 3'b001;
    bus.req  = 3'b000;
    tick();
    bus.done = 3'b000;
    chk("t5_rel", 32'(bus.gnt), 0);
    tick();

    // 4: owner 2 never finishes
    bus.req = 3'b100;
    exp_q.push_back(2);
    wait_grant("t4", e);
    hold = 0;
    while (bus.gnt !== '0 && hold < 120) begin
      hold++;
      tick();
    end
`ifdef PCI_ARB_TIMEOUT_EN
    chk("t4_hold_cycles", 32'(hold), 32'(TIMEOUT));
    chk("t4_terr_pulse",  32'(bus.timeout_err), 1);
    chk("t4_id",          32'(bus.gnt_id), 2);
    bus.req = 3'b000;
    tick();
    chk("t4_terr_end", 32'(bus.timeout_err), 0);
`else
    chk("t4_hold_cycles", 32'(hold), 120);
    chk("t4_terr_off",    32'(bus.timeout_err), 0);
    bus.done = 3'b100;
    bus.req  = 3'b000;
    tick();
    bus.done = 3'b000;
    chk("t4_rel", 32'(bus.gnt), 0);
    tick();
`endif
    tick();

    // 6: asynchronous reset in the middle of an ownership
    bus.req = 3'b001;
    exp_q.push_back(0);
    wait_grant("t6a", e);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("t6_async_gnt",   32'(bus.gnt), 0);
    chk("t6_async_busy",  32'(bus.busy), 0);
    chk("t6_async_state", 32'(state_o), 0);
    bus.req = 3'b000;
    tick();
    rst = 1'b1;
    bus.req = 3'b110;
    exp_q.push_back(1);
    wait_grant("t6b", e);
    bus.done = 3'b010;
    bus.req  = 3'b000;
    tick();
    bus.done = 3'b000;
    chk("t6_rel", 32'(bus.gnt), 0);

    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
